led_pattern_bank: RTL and testbench

Multi-channel LED pattern generator that replaces the single hard-coded blink counter in the top level. A shared prescaler produces a tick; each of NB_CH channels independently drives one LED as off, on, blink or burst pattern from a run-time half-period. Sits in the sys_clk domain between the top level's switch/key logic and the LED output pins.

---
 rtl/led_pattern_bank.sv | 185 ++++++++++++++++++
 tb/tb_led_pattern_bank.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_bank.sv
// -----------------------------------------------------------------------------
// led_pattern_bank
//
// Multi-channel LED pattern generator. A shared prescaler produces a one-cycle
// tick every TICK_DIV cycles. Each channel drives one LED as off, on, blink or
// burst. The blink and burst timing comes from a run-time half-period that is
// counted in ticks.
//
// Parameters
//   NB_CH     number of LED channels (1..16)
//   TICK_DIV  sys_clk cycles per tick
//   HALF_W    width of half_period
//   BURST_N   lit pulses per burst frame (1..8)
//
// Ports
//   sys_clk      in   system clock
//   sys_rst      in   synchronous, active-high reset
//   mode         in   per-channel mode, channel i = mode[2i+1:2i]
//                     00 off, 01 on, 10 blink, 11 burst
//   half_period  in   half-period in ticks, shared by all channels (0 acts as 1)
//   restart      in   one-cycle pulse: realigns the prescaler and all channel phases
//   led          out  registered LED drive, 1 = lit
//   tick         out  registered one-cycle prescaler pulse
// -----------------------------------------------------------------------------
module led_pattern_bank #(
  parameter int NB_CH    = 8,
  parameter int TICK_DIV = 100000,
  parameter int HALF_W   = 10,
  parameter int BURST_N  = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [2*NB_CH-1:0]  mode,
  input  logic [HALF_W-1:0]   half_period,
  input  logic                restart,
  output logic [NB_CH-1:0]    led,
  output logic                tick
);

  // Prescaler width. Keep at least one bit so that TICK_DIV = 1 still elaborates.
  localparam int PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // A burst frame has BURST_N lit/dark pairs followed by 4 dark half-periods.
  localparam int HP_N = 2 * BURST_N + 4;
  localparam int HP_W = $clog2(HP_N);

  localparam logic [PC_W-1:0] PC_LAST       = PC_W'(TICK_DIV - 1);
  localparam logic [HP_W-1:0] HP_LAST_BLINK = HP_W'(1);
  localparam logic [HP_W-1:0] HP_LAST_BURST = HP_W'(HP_N - 1);
  localparam logic [HP_W-1:0] HP_LIT_END    = HP_W'(2 * BURST_N);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } ch_mode_e;

  // Parameter sanity checks at elaboration time.
  if (NB_CH < 1 || NB_CH > 16) begin : g_bad_nb_ch
    $error("led_pattern_bank: NB_CH must be in 1..16");
  end
  if (BURST_N < 1 || BURST_N > 8) begin : g_bad_burst_n
    $error("led_pattern_bank: BURST_N must be in 1..8");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("led_pattern_bank: TICK_DIV must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            tick_q;
  logic            tick_d;

  always_comb begin
    pc_d   = pc_q + PC_W'(1);
    tick_d = (pc_q == PC_LAST);
    if (pc_q == PC_LAST) begin
      pc_d = '0;
    end
    // A restart makes the prescaler look as if it had just left reset, so the
    // next tick arrives a full TICK_DIV cycles later.
    if (restart) begin
      pc_d   = '0;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pc_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  // Last phase value of a half-period. A half_period of 0 behaves like 1.
  logic [HALF_W-1:0] ph_limit;
  assign ph_limit = (half_period == '0) ? '0 : (half_period - HALF_W'(1));

  // ---------------------------------------------------------------------------
  // Per-channel pattern engines
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NB_CH; gi++) begin : g_ch
    ch_mode_e          mode_in;
    ch_mode_e          mode_q;
    logic [HALF_W-1:0] ph_q;
    logic [HALF_W-1:0] ph_d;
    logic [HP_W-1:0]   hp_q;
    logic [HP_W-1:0]   hp_d;
    logic              hp_wrap;
    logic              led_q;
    logic              led_d;

    assign mode_in = ch_mode_e'(mode[2*gi +: 2]);

    // Next phase / half-period index. The LED value is decoded from the
    // post-edge state, so it changes on the same edge as the counters.
    always_comb begin
      ph_d    = ph_q;
      hp_d    = hp_q;
      led_d   = 1'b0;
      hp_wrap = (mode_q == MODE_BURST) ? (hp_q >= HP_LAST_BURST)
                                       : (hp_q >= HP_LAST_BLINK);

      if (restart || (mode_in != mode_q)) begin
        // Realign: a mode change or restart starts the pattern from its
        // beginning, and a tick on this same edge is not counted.
        ph_d = '0;
        hp_d = '0;
      end else begin
        case (mode_q)
          MODE_OFF, MODE_ON: begin
            ph_d = '0;
            hp_d = '0;
          end
          default: begin
            if (tick_q) begin
              // '>=' rather than '==' so that shrinking half_period below the
              // current phase wraps on the very next tick instead of running
              // the phase counter all the way round.
              if (ph_q >= ph_limit) begin
                ph_d = '0;
                hp_d = hp_wrap ? '0 : (hp_q + HP_W'(1));
              end else begin
                ph_d = ph_q + HALF_W'(1);
              end
            end
          end
        endcase
      end

      case (mode_in)
        MODE_OFF:   led_d = 1'b0;
        MODE_ON:    led_d = 1'b1;
        MODE_BLINK: led_d = (hp_d == '0);
        MODE_BURST: led_d = (hp_d < HP_LIT_END) && !hp_d[0];
      endcase
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        mode_q <= MODE_OFF;
        ph_q   <= '0;
        hp_q   <= '0;
        led_q  <= 1'b0;
      end else begin
        mode_q <= mode_in;
        ph_q   <= ph_d;
        hp_q   <= hp_d;
        led_q  <= led_d;
      end
    end

    assign led[gi] = led_q;
  end

endmodule

// File: tb/tb_led_pattern_bank.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_bank
//
// Self-checking bench for led_pattern_bank (NB_CH=4, TICK_DIV=4, HALF_W=4,
// BURST_N=2). It applies a table of reset/start-up vectors, runs hand-written
// multi-cycle sequences, and then drives random stimulus. A reference model
// follows every clock edge. The model counts ticks since the last realignment
// and derives each LED from (ticks / H) modulo the pattern length.
// -----------------------------------------------------------------------------
module tb_led_pattern_bank;

  localparam int NB_CH    = 4;
  localparam int TICK_DIV = 4;
  localparam int HALF_W   = 4;
  localparam int BURST_N  = 2;

  logic                clk = 1'b0;
  logic                sys_rst;
  logic [2*NB_CH-1:0]  mode;
  logic [HALF_W-1:0]   half_period;
  logic                restart;
  logic [NB_CH-1:0]    led;
  logic                tick;

  always #5 clk = ~clk;

  led_pattern_bank #(
    .NB_CH    (NB_CH),
    .TICK_DIV (TICK_DIV),
    .HALF_W   (HALF_W),
    .BURST_N  (BURST_N)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .mode        (mode),
    .half_period (half_period),
    .restart     (restart),
    .led         (led),
    .tick        (tick)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int               m_c;              // edges since reset/restart
  bit               m_tick;
  bit [1:0]         m_prev [NB_CH];
  int               m_n    [NB_CH];   // ticks counted since channel realigned
  bit [NB_CH-1:0]   m_led;
  bit               m_started = 1'b0;
  bit               m_valid   = 1'b0; // H constant since last alignment
  int               m_last_h  = 1;

  function automatic bit pattern_bit(input bit [1:0] md, input int n, input int h);
    int idx;
    case (md)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return ((n / h) % 2) == 0;
      default: begin
        idx = (n / h) % (2 * BURST_N + 4);
        return (idx < 2 * BURST_N) && ((idx % 2) == 0);
      end
    endcase
  endfunction

  task automatic model_edge();
    bit t_before;
    int h;
    h = (half_period == '0) ? 1 : int'(half_period);
    if (sys_rst) begin
      m_c = 0;
      m_tick = 1'b0;
      for (int i = 0; i < NB_CH; i++) begin
        m_prev[i] = 2'b00;
        m_n[i]    = 0;
      end
      m_led     = '0;
      m_started = 1'b1;
      m_valid   = 1'b1;
      m_last_h  = h;
      return;
    end
    if (restart) m_valid = 1'b1;
    else if (h != m_last_h) m_valid = 1'b0;
    m_last_h = h;
    t_before = m_tick;
    if (restart) begin
      m_c    = 0;
      m_tick = 1'b0;
    end else begin
      m_c++;
      m_tick = (m_c % TICK_DIV) == 0;
    end
    for (int i = 0; i < NB_CH; i++) begin
      bit [1:0] md;
      md = mode[2*i +: 2];
      if (restart || md != m_prev[i]) m_n[i] = 0;
      else if (md < 2'b10)            m_n[i] = 0;
      else if (t_before)              m_n[i]++;
      m_prev[i] = md;
      m_led[i]  = pattern_bit(md, m_n[i], h);
    end
  endtask

  // One clock edge: update the model with the inputs the DUT sampled, then
  // compare 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (m_started) begin
      check("model_tick", int'(tick), int'(m_tick));
      if (m_valid) check("model_led", int'(led), int'(m_led));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Start-up vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic               rst;
    logic [2*NB_CH-1:0] md;
    logic [HALF_W-1:0]  hp;
    logic               rs;
    logic [NB_CH-1:0]   exp_led;
    logic               exp_tick;
  } vec_t;

  vec_t vecs [13];

  task automatic run_table(input string tag);
    for (int i = 0; i < 13; i++) begin
      sys_rst     = vecs[i].rst;
      mode        = vecs[i].md;
      half_period = vecs[i].hp;
      restart     = vecs[i].rs;
      step();
      check({tag, "_led"},  int'(led),  int'(vecs[i].exp_led));
      check({tag, "_tick"}, int'(tick), int'(vecs[i].exp_tick));
      $display("%s[%0d] rst=%0b mode=%h led=%h tick=%0b", tag, i, vecs[i].rst,
               vecs[i].md, led, tick);
    end
  endtask

  // Measures one full dark run followed by one full lit run on led[0].
  task automatic measure_runs(output int dark, output int lit);
    int n;
    n = 0;
    while (led[0] !== 1'b0 && n < 64) begin step(); n++; end
    dark = 0; n = 0;
    while (led[0] === 1'b0 && n < 64) begin dark++; step(); n++; end
    lit = 0; n = 0;
    while (led[0] === 1'b1 && n < 64) begin lit++; step(); n++; end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int dark, lit;
    bit found;
    bit [7:0] burst_pat;
    bit exp_bit;

    sys_rst     = 1'b1;
    mode        = '0;
    half_period = 4'd2;
    restart     = 1'b0;

    // reset for 3 edges with mode all blink, then release
    vecs[0]  = '{1'b1, 8'hAA, 4'd2, 1'b0, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 8'hAA, 4'd2, 1'b0, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 8'hAA, 4'd2, 1'b0, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'hF, 1'b0};  // edge 1: pattern start
    vecs[4]  = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'hF, 1'b0};
    vecs[5]  = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'hF, 1'b0};
    vecs[6]  = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'hF, 1'b1};  // edge 4: first tick
    vecs[7]  = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'hF, 1'b0};
    vecs[8]  = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'hF, 1'b0};
    vecs[9]  = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'hF, 1'b0};
    vecs[10] = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'hF, 1'b1};  // edge 8: second tick
    vecs[11] = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'h0, 1'b0};  // edge 9: half-period ends
    vecs[12] = '{1'b0, 8'hAA, 4'd2, 1'b0, 4'h0, 1'b0};

    run_table("startup");

    // Prescaler realignment from an arbitrary pc.
    step();
    pulse_restart();
    check("restart_tick_clear", int'(tick), 0);
    for (k = 1; k <= 8; k++) begin step(); if (tick) break; end
    check("restart_to_tick", k, 4);
    for (k = 1; k <= 8; k++) begin step(); if (tick) break; end
    check("tick_period", k, 4);
    $display("prescaler restart checked");

    // Blink timing, H=2 then H=0.
    mode = 8'hAA; half_period = 4'd2;
    pulse_restart();
    measure_runs(dark, lit);
    check("blink_h2_dark", dark, 8);
    check("blink_h2_lit",  lit,  8);
    $display("blink h=2 dark=%0d lit=%0d", dark, lit);
    half_period = 4'd0;
    pulse_restart();
    measure_runs(dark, lit);
    check("blink_h0_dark", dark, 4);
    check("blink_h0_lit",  lit,  4);
    $display("blink h=0 dark=%0d lit=%0d", dark, lit);

    // Burst, H=1: per-tick pattern 1,0,1,0,0,0,0,0.
    burst_pat = 8'b0000_0101;
    mode = 8'hFF; half_period = 4'd1;
    pulse_restart();
    for (int t = 0; t < 16; t++) begin
      if (t == 0) step();
      else repeat (4) step();
      exp_bit = burst_pat[t % 8];
      check("burst_pattern", int'(led), exp_bit ? 15 : 0);
    end
    $display("burst frame checked");

    // Channel 1 switches blink -> burst while dark, on a tick edge.
    mode = 8'hAA; half_period = 4'd2;
    pulse_restart();
    found = 1'b0;
    for (int n = 0; n < 64; n++) begin
      step();
      if (led[1] == 1'b0 && tick == 1'b1) begin found = 1'b1; break; end
    end
    check("mode_change_setup", int'(found), 1);
    mode = 8'hAE;
    step();
    check("mode_change_edge", int'(led), 4'h2);
    repeat (7) step();
    check("mode_change_plus7", int'(led), 4'hF);
    step();
    check("mode_change_plus8", int'(led), 4'hD);
    $display("mode change on channel 1 checked led=%h", led);

    // Reset mid-pattern: the start-up sequence must repeat exactly.
    run_table("rerun");

    // Reduced half_period wraps on the next tick.
    mode = 8'hAA; half_period = 4'd4;
    pulse_restart();
    repeat (5) step();
    check("hp_shrink_before", int'(led), 4'hF);
    half_period = 4'd1;
    repeat (3) step();
    check("hp_shrink_hold", int'(led), 4'hF);
    step();
    check("hp_shrink_wrap", int'(led), 4'h0);
    repeat (4) step();
    check("hp_shrink_next", int'(led), 4'hF);
    $display("half_period shrink checked");

    // Random stimulus against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      sys_rst = ($urandom_range(0, 499) == 0);
      restart = ($urandom_range(0, 39) == 0);
      if (restart) half_period = HALF_W'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0)
        mode[2*$urandom_range(0, NB_CH-1) +: 2] = 2'($urandom_range(0, 3));
      step();
      if (cyc % 500 == 499)
        $display("random cycle %0d mode=%h hp=%0d led=%h", cyc, mode, half_period, led);
    end
    sys_rst = 1'b0;
    restart = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
